// File: rtl/crc16_receiver.sv
// CRC-16 receiver: accepts a 39-bit {message, crc} codeword and divides it bit-serially, MSB first.
// Define CRC16_RX_ERR_COUNT_EN to add a saturating err_count output for bad words handed off.
module crc16_receiver #(
    parameter logic [15:0] POLY = 16'h8005
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [38:0] codeword,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [22:0] message,
    output logic [15:0] syndrome,
    output logic        crc_ok,
`ifdef CRC16_RX_ERR_COUNT_EN
    output logic [7:0]  err_count,
`endif
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its data stable until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [38:0] shreg_q, shreg_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [22:0] msg_q, msg_d;
    logic        ok_q, ok_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            msg_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        msg_d     = msg_q;
        ok_d      = ok_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d = codeword;
                    lfsr_d  = '0;
                    cnt_d   = 6'd38;
                    msg_d   = codeword[38:16];
                    ok_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Plain division (no augmentation): the remainder is codeword mod g(x).
                lfsr_d  = {lfsr_q[14:0], shreg_q[38]} ^ (lfsr_q[15] ? POLY : 16'h0000);
                shreg_d = {shreg_q[37:0], 1'b0};
                if (cnt_q == 6'd0) begin
                    cnt_d   = 6'd0;
                    ok_d    = (lfsr_d == 16'h0000);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign message     = msg_q;
    assign syndrome    = lfsr_q;
    assign crc_ok      = ok_q;
    assign dbg_state_o = state_q;

`ifdef CRC16_RX_ERR_COUNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (state_q == DONE && out_ready && !ok_q && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_crc16_receiver.sv
// Bench for crc16_receiver: fixed vectors, random words against a long-division model,
// backpressure, mid-word reset and (when CRC16_RX_ERR_COUNT_EN is defined) the error counter.
module tb_crc16_receiver;

    localparam logic [15:0] POLY = 16'h8005;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [38:0] codeword;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] message;
    logic [15:0] syndrome;
    logic        crc_ok;
    logic [1:0]  dbg_state;
`ifdef CRC16_RX_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    crc16_receiver #(.POLY(POLY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .codeword   (codeword),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .message    (message),
        .syndrome   (syndrome),
        .crc_ok     (crc_ok),
`ifdef CRC16_RX_ERR_COUNT_EN
        .err_count  (err_count),
`endif
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: polynomial long division of the 39-bit codeword by x^16 + POLY.
    function automatic logic [15:0] model_rem(input logic [38:0] cw);
        logic [38:0] r;
        logic [38:0] g;
        r = cw;
        g = {22'd0, 1'b1, POLY};
        for (int i = 38; i >= 16; i--)
            if (r[i]) r = r ^ (g << (i - 16));
        return r[15:0];
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        codeword  = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // driver: send one word, wait for the result, optionally hand it off
    task automatic send_and_wait(input logic [38:0] cw, input string tag,
                                 output logic [22:0] g_msg, output logic [15:0] g_syn,
                                 output logic g_ok, output bit got);
        int n;
        got = 0;
        g_msg = '0; g_syn = '0; g_ok = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({tag, " in_ready_timeout"}, 0, 1);
            return;
        end
        in_valid = 1'b1;
        codeword = cw;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        codeword = $urandom();
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        check({tag, " latency"}, 64'(n), 64'd39);
        if (!out_valid) return;
        got = 1;
        g_msg = message;
        g_syn = syndrome;
        g_ok  = crc_ok;
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid_after_handoff"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready_after_handoff"}, 64'(in_ready), 64'd1);
    endtask

    typedef struct {
        logic [38:0] cw;
        logic [22:0] msg;
        logic [15:0] syn;
        logic        ok;
    } vec_t;

    vec_t vecs[4];
    logic [38:0] exp_q[$];

    initial begin
        logic [22:0] g_msg;
        logic [15:0] g_syn;
        logic        g_ok;
        bit          got;
        logic [38:0] cw;
        logic [22:0] hold_msg;
        logic [15:0] hold_syn;
        logic        hold_ok;
        int          seen;

        vecs[0] = '{cw: 39'h0,          msg: 23'h0,      syn: 16'h0000, ok: 1'b1};
        vecs[1] = '{cw: 39'h0000000001, msg: 23'h0,      syn: 16'h0001, ok: 1'b0};
        vecs[2] = '{cw: 39'h0000010000, msg: 23'h000001, syn: 16'h8005, ok: 1'b0};
        vecs[3] = '{cw: 39'h0000018005, msg: 23'h000001, syn: 16'h0000, ok: 1'b1};

        // reset state, observed while reset is still asserted
        in_valid = 1'b0; out_ready = 1'b0; codeword = '0; rst_n = 1'b0;
        #12;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst message", 64'(message), 64'd0);
        check("rst syndrome", 64'(syndrome), 64'd0);
        check("rst crc_ok", 64'(crc_ok), 64'd0);
        do_reset();

        // table-driven vectors
        for (int i = 0; i < 4; i++) begin
            send_and_wait(vecs[i].cw, $sformatf("vec%0d", i), g_msg, g_syn, g_ok, got);
            if (got) begin
                check($sformatf("vec%0d message", i), 64'(g_msg), 64'(vecs[i].msg));
                check($sformatf("vec%0d syndrome", i), 64'(g_syn), 64'(vecs[i].syn));
                check($sformatf("vec%0d crc_ok", i), 64'(g_ok), 64'(vecs[i].ok));
                handoff($sformatf("vec%0d", i));
            end
        end

        // random words: half corrupted at random, half built as valid codewords
        for (int i = 0; i < 40; i++) begin
            cw = {$urandom(), $urandom()};
            if (i % 2 == 0) cw[15:0] = model_rem({cw[38:16], 16'h0000});
            if (i % 6 == 0) cw[$urandom_range(38, 0)] ^= 1'b1;
            exp_q.push_back(cw);
        end
        while (exp_q.size() > 0) begin
            cw = exp_q.pop_front();
            send_and_wait(cw, "rand", g_msg, g_syn, g_ok, got);
            if (got) begin
                check("rand message", 64'(g_msg), 64'(cw[38:16]));
                check("rand syndrome", 64'(g_syn), 64'(model_rem(cw)));
                check("rand crc_ok", 64'(g_ok), 64'(model_rem(cw) == 16'h0000));
                handoff("rand");
            end
        end

        // backpressure: hold DONE for 10 cycles while in_valid pulses
        cw = 39'h12_3456_789A;
        send_and_wait(cw, "bp", g_msg, g_syn, g_ok, got);
        if (got) begin
            hold_msg = g_msg; hold_syn = g_syn; hold_ok = g_ok;
            check("bp syndrome", 64'(g_syn), 64'(model_rem(cw)));
            for (int c = 0; c < 10; c++) begin
                in_valid = c[0];
                codeword = 39'h7F_FFFF_FFFF;
                @(posedge clk);
                #1;
                check("bp out_valid", 64'(out_valid), 64'd1);
                check("bp in_ready", 64'(in_ready), 64'd0);
                check("bp message", 64'(message), 64'(hold_msg));
                check("bp syndrome_hold", 64'(syndrome), 64'(hold_syn));
                check("bp crc_ok_hold", 64'(crc_ok), 64'(hold_ok));
            end
            // in_valid stays high across the exit edge: must not be taken on that edge
            in_valid = 1'b1;
            handoff("bp");
            check("bp message_not_reloaded", 64'(message), 64'(hold_msg));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp accept_next_edge", 64'(in_ready), 64'd0);
            check("bp message_loaded", 64'(message), 64'(39'h7F_FFFF_FFFF >> 16));
            do_reset();
        end

        // reset in the middle of SHIFT
        @(negedge clk);
        in_valid = 1'b1;
        codeword = 39'h0000010000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst syndrome", 64'(syndrome), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst no_out_valid", 64'(seen), 64'd0);
        cw = 39'h0000018005;
        send_and_wait(cw, "postrst", g_msg, g_syn, g_ok, got);
        if (got) begin
            check("postrst syndrome", 64'(g_syn), 64'd0);
            check("postrst crc_ok", 64'(g_ok), 64'd1);
            handoff("postrst");
        end

`ifdef CRC16_RX_ERR_COUNT_EN
        do_reset();
        check("err reset", 64'(err_count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cw = (i == 2) ? 39'h0000018005 : 39'h0000000001 + 39'(i);
            send_and_wait(cw, "err", g_msg, g_syn, g_ok, got);
            if (got) handoff("err");
        end
        check("err count3", 64'(err_count), 64'd3);
        do_reset();
        for (int i = 0; i < 260; i++) begin
            send_and_wait(39'h0000000001, "errsat", g_msg, g_syn, g_ok, got);
            if (!got) break;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        check("err saturate", 64'(err_count), 64'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crc16_receiver.md
CRC16_RECEIVER -- requirements
Module: crc16_receiver

Interface
REQ-001 SHALL have parameter: POLY, 16'h8005, CRC-16 generator low 16 bits (x^16 implicit), matching the sender's polynomial.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  codeword present.
REQ-005 SHALL have port: in_ready  output  1  block can accept a codeword.
REQ-006 SHALL have port: codeword  input  39  {message[22:0], crc[15:0]} as produced by the sender stage.
REQ-007 SHALL have port: out_valid  output  1  result available.
REQ-008 SHALL have port: out_ready  input  1  consumer takes result.
REQ-009 SHALL have port: message  output  23  codeword[38:16] of accepted word.
REQ-010 SHALL have port: syndrome  output  16  codeword mod (x^16+POLY).
REQ-011 SHALL have port: crc_ok  output  1  syndrome == 0.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid, latch codeword into a 39-bit shift register, clear the LFSR, load a bit counter with 38, go to SHIFT.
REQ-014 SHIFT: in_ready=0; each cycle feed one codeword bit, MSB first (bit 38 first), via r <= {r[14:0],b} ^ (r[15] ? POLY : 0).
REQ-015 SHIFT: the counter decrements per cycle; on the cycle it processes bit 0, go to DONE.
REQ-016 Latency: accept at edge E; bits processed on edges E+1..E+39; out_valid=1 after edge E+39.
REQ-017 DONE: out_valid=1; message, syndrome, crc_ok stable; in_ready=0.
REQ-018 DONE with out_ready=1: return to IDLE on that edge; out_valid drops after it.
REQ-019 DONE with out_ready=0: hold DONE and all outputs indefinitely (backpressure).
REQ-020 in_valid during SHIFT or DONE SHALL be ignored; the upstream stage holds its word until in_ready=1.
REQ-021 No codeword is accepted on the same edge DONE exits; the earliest next acceptance is the edge after returning to IDLE.
REQ-022 message SHALL be registered at acceptance; syndrome/crc_ok SHALL be valid only while out_valid=1.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, and clear LFSR, counter, shift register, message, syndrome and crc_ok to 0; out_valid=0, in_ready=1 from the next cycle after deassertion.
REQ-024 Reset asserted mid-SHIFT or in DONE SHALL discard the word in flight; no out_valid is produced for it.

Configuration
REQ-025 Macro CRC16_RX_ERR_COUNT_EN SHALL compile in an extra output err_count (8 bits).
REQ-026 With the macro defined: err_count increments by 1 on each DONE->IDLE handshake where crc_ok=0, saturates at 8'hFF, and resets to 0 on rst_n.
REQ-027 Without the macro: no err_count port or logic; all other behaviour identical.

Verification
REQ-028 codeword=39'h0 -> out_valid 39 cycles after the accept cycle, syndrome=16'h0000, crc_ok=1, message=23'h0.
REQ-029 codeword=39'h0000000001 -> syndrome=16'h0001, crc_ok=0.
REQ-030 codeword=39'h0000010000 -> message=23'h000001, syndrome=16'h8005, crc_ok=0; codeword=39'h0000018005 -> syndrome=16'h0000, crc_ok=1.
REQ-031 out_ready held 0 for 10 cycles in DONE -> out_valid and outputs stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next edge.
REQ-032 rst_n pulsed low at SHIFT cycle 20 -> immediate IDLE, no out_valid; the next word is then processed correctly.
REQ-033 With CRC16_RX_ERR_COUNT_EN: 3 bad words and 1 good word handed off -> err_count=3; 260 bad words -> err_count=8'hFF.
